// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// State encoding is fixed at 3 bits so the state can be probed on a debug bus.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } seq_state_e;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and core-side signals of the lock sequencer.
// master = sequencer, slave = PLL/core environment.
interface pll_lock_sequencer_if;

    logic       pll_locked;
    logic       req_relock;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked, req_relock,
        output pll_rst, sys_reset, ready, fault, retry_count, lock_loss_cnt
    );

    modport slave (
        output pll_locked, req_relock,
        input  pll_rst, sys_reset, ready, fault, retry_count, lock_loss_cnt
    );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous clear, for single-bit level signals
// crossing into the refclk domain.
module pll_lock_sequencer_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for a stable synchronized lock, then releases the
// core reset. Retries on lock timeout, restarts on lock loss or relock request.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input logic                  refclk,
    input logic                  rst,
    pll_lock_sequencer_if.master seq
);

    localparam int unsigned PulseW   = cnt_width(RST_PULSE_CYCLES);
    localparam int unsigned StableW  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TimeoutW = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [PulseW-1:0]   PulseLen   = PulseW'(RST_PULSE_CYCLES);
    localparam logic [StableW-1:0]  StableLen  = StableW'(LOCK_STABLE_CYCLES);
    localparam logic [TimeoutW-1:0] TimeoutLen = TimeoutW'(LOCK_TIMEOUT_CYCLES);
    // retry_count saturates at 3, so a larger limit behaves as 3.
    localparam logic [1:0] RetryLimit = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    seq_state_e state_q, state_d;

    logic [PulseW-1:0]   pulse_q, pulse_d, pulse_inc;
    logic [StableW-1:0]  stable_q, stable_d, stable_inc;
    logic [TimeoutW-1:0] timeout_q, timeout_d, timeout_inc;
    logic [1:0]          retry_q, retry_d, retry_inc;
    logic [7:0]          loss_q, loss_d, loss_inc;

    logic pll_rst_q, sys_reset_q, ready_q, fault_q;
    logic locked_s;
    logic timeout_hit;
    seq_state_e retry_next;

    pll_lock_sequencer_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (seq.pll_locked),
        .q   (locked_s)
    );

    assign pulse_inc   = pulse_q + PulseW'(1);
    assign stable_inc  = stable_q + StableW'(1);
    assign timeout_inc = timeout_q + TimeoutW'(1);
    assign retry_inc   = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    assign loss_inc    = (loss_q == 8'hff) ? 8'hff : loss_q + 8'd1;
    assign timeout_hit = (timeout_inc == TimeoutLen);
    assign retry_next  = (retry_inc == RetryLimit) ? StFault : StPllRst;

    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        stable_d  = stable_q;
        timeout_d = timeout_q;
        retry_d   = retry_q;
        loss_d    = loss_q;

        if (seq.req_relock) begin
            // Relock overrides everything, including a lock loss in the same cycle.
            state_d   = StPllRst;
            pulse_d   = '0;
            stable_d  = '0;
            timeout_d = '0;
            retry_d   = '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (pulse_inc == PulseLen) begin
                        state_d = StWaitLock;
                        pulse_d = '0;
                    end else begin
                        pulse_d = pulse_inc;
                    end
                end
                StWaitLock: begin
                    timeout_d = timeout_inc;
                    if (timeout_hit) begin
                        state_d   = retry_next;
                        retry_d   = retry_inc;
                        timeout_d = '0;
                    end else if (locked_s) begin
                        // The first locked cycle already counts toward stability.
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d   = StRun;
                            timeout_d = '0;
                        end else begin
                            state_d  = StStable;
                            stable_d = StableW'(1);
                        end
                    end
                end
                StStable: begin
                    timeout_d = timeout_inc;
                    if (locked_s && (stable_inc == StableLen)) begin
                        state_d   = StRun;
                        stable_d  = '0;
                        timeout_d = '0;
                    end else if (timeout_hit) begin
                        state_d   = retry_next;
                        retry_d   = retry_inc;
                        stable_d  = '0;
                        timeout_d = '0;
                    end else if (!locked_s) begin
                        state_d  = StWaitLock;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_inc;
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_d = StPllRst;
                        loss_d  = loss_inc;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StPllRst;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= StPllRst;
            pulse_q     <= '0;
            stable_q    <= '0;
            timeout_q   <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            stable_q    <= stable_d;
            timeout_q   <= timeout_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs decoded from next state so they are registered yet track the state.
            pll_rst_q   <= (state_d == StPllRst);
            sys_reset_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
        end
    end

    assign seq.pll_rst       = pll_rst_q;
    assign seq.sys_reset     = sys_reset_q;
    assign seq.ready         = ready_q;
    assign seq.fault         = fault_q;
    assign seq.retry_count   = retry_q;
    assign seq.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: expected output-change events (cycle, outputs) are
// queued per scenario and matched against changes recorded by a negedge monitor.
module tb_pll_lock_sequencer;

    typedef struct packed {
        int          cyc;
        logic [13:0] v;   // {pll_rst, sys_reset, ready, fault, retry_count, lock_loss_cnt}
    } ev_t;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   cyc;
    int   total  = 0;
    int   bad    = 0;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [13:0] prev;
    logic [13:0] cur;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .seq    (bus)
    );

    always #10 refclk = ~refclk;

    // Cycle k = interval after the k-th rising edge since reset release.
    always @(posedge refclk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [13:0] pk(input bit pr, input bit sr, input bit rd, input bit ft,
                                       input logic [1:0] rc, input logic [7:0] lc);
        return {pr, sr, rd, ft, rc, lc};
    endfunction

    always @(negedge refclk) begin
        cur = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fault, bus.retry_count,
               bus.lock_loss_cnt};
        if (!rst && (cur !== prev)) obs_q.push_back('{cyc: cyc, v: cur});
        prev = cur;
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge refclk);
    endtask

    task automatic restart();
        rst = 1'b1;
        repeat (3) @(negedge refclk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.pll_locked = 1'b0;
        bus.req_relock = 1'b0;
        repeat (3) @(negedge refclk);
        #1;
        total++; if (bus.pll_rst !== 1'b1) begin bad++; $display("FAIL reset pll_rst got=%b want=1", bus.pll_rst); end
        total++; if (bus.sys_reset !== 1'b1) begin bad++; $display("FAIL reset sys_reset got=%b want=1", bus.sys_reset); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset ready got=%b want=0", bus.ready); end
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset fault got=%b want=0", bus.fault); end
        total++; if (bus.retry_count !== 2'd0) begin bad++; $display("FAIL reset retry_count got=%0d want=0", bus.retry_count); end
        total++; if (bus.lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL reset lock_loss_cnt got=%0d want=0", bus.lock_loss_cnt); end
    endtask

    task automatic test_lock_fast();
        ev_t e, o;
        restart();
        exp_q.push_back('{cyc: 4,  v: pk(0, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 16, v: pk(0, 0, 1, 0, 0, 0)});
        wait_cyc(6);
        bus.pll_locked = 1'b1;
        wait_cyc(20);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL lock_fast event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL lock_fast extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
    endtask

    task automatic test_run_loss();
        ev_t e, o;
        exp_q.push_back('{cyc: 33, v: pk(1, 1, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: 37, v: pk(0, 1, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: 45, v: pk(0, 0, 1, 0, 0, 1)});
        wait_cyc(30);
        bus.pll_locked = 1'b0;
        wait_cyc(35);
        bus.pll_locked = 1'b1;
        wait_cyc(50);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL run_loss event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL run_loss extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
    endtask

    task automatic test_async_reset();
        ev_t e, o;
        exp_q.push_back('{cyc: 58, v: pk(1, 1, 0, 0, 0, 2)});
        exp_q.push_back('{cyc: 62, v: pk(0, 1, 0, 0, 0, 2)});
        wait_cyc(55);
        bus.pll_locked = 1'b0;
        wait_cyc(60);
        bus.pll_locked = 1'b1;
        wait_cyc(65);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL async_reset event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL async_reset extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
        // Mid-cycle reset while in STABLE: outputs must clear without a clock edge.
        rst = 1'b1;
        #1;
        cur = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fault, bus.retry_count, bus.lock_loss_cnt};
        total++;
        if (cur !== pk(1, 1, 0, 0, 0, 0)) begin bad++; $display("FAIL async_reset outputs got=%h want=%h", cur, pk(1, 1, 0, 0, 0, 0)); end
        restart();
        exp_q.push_back('{cyc: 4,  v: pk(0, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 12, v: pk(0, 0, 1, 0, 0, 0)});
        wait_cyc(16);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL async_restart event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL async_restart extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
    endtask

    task automatic test_stable_glitch();
        ev_t e, o;
        bus.pll_locked = 1'b0;
        restart();
        exp_q.push_back('{cyc: 4,  v: pk(0, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 22, v: pk(0, 0, 1, 0, 0, 0)});
        wait_cyc(6);
        bus.pll_locked = 1'b1;
        wait_cyc(11);
        bus.pll_locked = 1'b0;   // synced low for exactly cycle 13 (stable count 5)
        wait_cyc(12);
        bus.pll_locked = 1'b1;
        wait_cyc(26);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL stable_glitch event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL stable_glitch extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
    endtask

    task automatic test_timeout_fault();
        ev_t e, o;
        bus.pll_locked = 1'b0;
        restart();
        exp_q.push_back('{cyc: 4,  v: pk(0, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 36, v: pk(1, 1, 0, 0, 1, 0)});
        exp_q.push_back('{cyc: 40, v: pk(0, 1, 0, 0, 1, 0)});
        exp_q.push_back('{cyc: 72, v: pk(0, 1, 0, 1, 2, 0)});
        wait_cyc(85);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL timeout_fault event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL timeout_fault extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL timeout_fault fault got=%b want=1", bus.fault); end
        total++; if (bus.pll_rst !== 1'b0) begin bad++; $display("FAIL timeout_fault pll_rst got=%b want=0", bus.pll_rst); end
    endtask

    task automatic test_relock_fault();
        ev_t e, o;
        exp_q.push_back('{cyc: 91,  v: pk(1, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 95,  v: pk(0, 1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: 103, v: pk(0, 0, 1, 0, 0, 0)});
        wait_cyc(90);
        bus.req_relock = 1'b1;
        wait_cyc(91);
        bus.req_relock = 1'b0;
        wait_cyc(93);
        bus.pll_locked = 1'b1;
        wait_cyc(108);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '{cyc: -1, v: 'x};
            total++;
            if (o !== e) begin bad++; $display("FAIL relock_fault event got cyc=%0d v=%h want cyc=%0d v=%h", o.cyc, o.v, e.cyc, e.v); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL relock_fault extra got=%0d changes want=0 (first cyc=%0d)", obs_q.size(), obs_q[0].cyc); obs_q.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_fast();
        test_run_loss();
        test_async_reset();
        test_stable_glitch();
        test_timeout_fault();
        test_relock_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
